// File: rtl/laser500_mem_pkg.sv
// Shared SDRAM map for the BASIC program area plus the uploader state set.
// prg_len() turns the end-of-program pointer into a clamped byte count.
package laser500_mem_pkg;

  localparam int ADDR_W = 25;

  localparam logic [ADDR_W-1:0] PRG_START_ADDR = 25'h008995;
  localparam logic [ADDR_W-1:0] PTR_PROGND     = 25'h0083E9;
  localparam logic [15:0]       PTR_END_BASE   = 16'h8995;
  localparam logic [ADDR_W-1:0] MAX_LEN        = 25'h007000;

  typedef enum logic [3:0] {
    UP_IDLE,
    UP_PTR_LO,
    UP_PTR_HI,
    UP_CALC,
    UP_FETCH,
    UP_WAIT,
    UP_DRAIN,
    UP_SETTLE1,
    UP_SETTLE2
  } up_state_e;

  // A pointer below the program base means an empty program.
  function automatic logic [ADDR_W-1:0] prg_len(input logic [15:0] ptr);
    logic [15:0]       diff;
    logic [ADDR_W-1:0] len;
    diff = ptr - PTR_END_BASE;
    if (ptr < PTR_END_BASE) len = '0;
    else                    len = {9'd0, diff};
    if (len > MAX_LEN) len = MAX_LEN;
    return len;
  endfunction

endpackage

// File: rtl/uploader.sv
// Streams the BASIC program from SDRAM back to the IO controller one byte per
// ioctl_rd, holding the CPU off for the transfer plus two settle cycles.
module uploader
  import laser500_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_din_valid,
  output logic              ioctl_eof,
  output logic [ADDR_W-1:0] upload_len,
  output logic              len_valid,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              mem_ack,
  output logic              uploading,
  output logic              overrun
);

  up_state_e         state_q;
  logic              upload_q;
  logic [7:0]        ptr_lo_q, ptr_hi_q;
  logic [ADDR_W-1:0] index_q, len_q, addr_q;
  logic [7:0]        din_q;
  logic              valid_q, eof_q, len_valid_q, mem_rd_q, uploading_q, overrun_q;

  logic              up_rise, up_fall, active, rd_early;
  logic [ADDR_W-1:0] index_nxt, calc_len;

  assign up_rise   = ioctl_upload & ~upload_q;
  assign up_fall   = ~ioctl_upload & upload_q;
  assign active    = state_q inside {UP_PTR_LO, UP_PTR_HI, UP_CALC, UP_FETCH, UP_WAIT};
  assign rd_early  = ioctl_rd & (state_q inside {UP_PTR_LO, UP_PTR_HI, UP_CALC, UP_FETCH});
  assign index_nxt = index_q + 25'd1;
  assign calc_len  = prg_len({ptr_hi_q, ptr_lo_q});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= UP_IDLE;
      // Treat upload as already high so a level held through reset is not an edge.
      upload_q    <= 1'b1;
      ptr_lo_q    <= '0;
      ptr_hi_q    <= '0;
      index_q     <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      valid_q     <= 1'b0;
      eof_q       <= 1'b0;
      len_valid_q <= 1'b0;
      mem_rd_q    <= 1'b0;
      uploading_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      upload_q <= ioctl_upload;
      if (rd_early) overrun_q <= 1'b1;
      if (mem_ack)  mem_rd_q  <= 1'b0;

      if (up_fall && active) begin
        state_q     <= UP_DRAIN;
        valid_q     <= 1'b0;
        eof_q       <= 1'b0;
        len_valid_q <= 1'b0;
      end else begin
        case (state_q)
          UP_IDLE: if (up_rise) begin
            uploading_q <= 1'b1;
            overrun_q   <= 1'b0;
            index_q     <= '0;
            mem_rd_q    <= 1'b1;
            addr_q      <= PTR_PROGND;
            state_q     <= UP_PTR_LO;
          end
          UP_PTR_LO: if (mem_ack) begin
            ptr_lo_q <= mem_data;
            mem_rd_q <= 1'b1;
            addr_q   <= PTR_PROGND + 25'd1;
            state_q  <= UP_PTR_HI;
          end
          UP_PTR_HI: if (mem_ack) begin
            ptr_hi_q <= mem_data;
            state_q  <= UP_CALC;
          end
          UP_CALC: begin
            len_q       <= calc_len;
            len_valid_q <= 1'b1;
            index_q     <= '0;
            if (calc_len == '0) begin
              eof_q   <= 1'b1;
              state_q <= UP_WAIT;
            end else begin
              mem_rd_q <= 1'b1;
              addr_q   <= PRG_START_ADDR;
              state_q  <= UP_FETCH;
            end
          end
          UP_FETCH: if (mem_ack) begin
            din_q   <= mem_data;
            valid_q <= 1'b1;
            state_q <= UP_WAIT;
          end
          UP_WAIT: if (ioctl_rd && valid_q) begin
            valid_q <= 1'b0;
            index_q <= index_nxt;
            if (index_nxt == len_q) begin
              eof_q <= 1'b1;
              din_q <= 8'h00;
            end else begin
              mem_rd_q <= 1'b1;
              addr_q   <= PRG_START_ADDR + index_nxt;
              state_q  <= UP_FETCH;
            end
          end
          // An outstanding read must complete before the SDRAM mux is handed back.
          UP_DRAIN: if (!mem_rd_q || mem_ack) begin
            mem_rd_q <= 1'b0;
            state_q  <= UP_SETTLE1;
          end
          UP_SETTLE1: state_q <= UP_SETTLE2;
          UP_SETTLE2: begin
            uploading_q <= 1'b0;
            state_q     <= UP_IDLE;
          end
          default: state_q <= UP_IDLE;
        endcase
      end
    end
  end

  assign ioctl_din       = din_q;
  assign ioctl_din_valid = valid_q;
  assign ioctl_eof       = eof_q;
  assign upload_len      = len_q;
  assign len_valid       = len_valid_q;
  assign mem_rd          = mem_rd_q;
  assign mem_addr        = addr_q;
  assign uploading       = uploading_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_uploader.sv
// Directed bench for uploader with a small latency-configurable SDRAM model.
module tb_uploader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_upload = 1'b1;
  logic        ioctl_rd = 1'b0;
  logic [7:0]  ioctl_din;
  logic        ioctl_din_valid, ioctl_eof, len_valid, mem_rd, uploading, overrun;
  logic [24:0] upload_len, mem_addr;
  logic [7:0]  mem_data = 8'h00;
  logic        mem_ack = 1'b0;

  uploader dut (
    .clk(clk), .reset_n(reset_n),
    .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_din(ioctl_din), .ioctl_din_valid(ioctl_din_valid), .ioctl_eof(ioctl_eof),
    .upload_len(upload_len), .len_valid(len_valid),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .uploading(uploading), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SDRAM model: ack after lat cycles of mem_rd; hold_fetch stalls program-area reads.
  logic [7:0] ptr_lo = 8'h00, ptr_hi = 8'h00;
  int lat = 1;
  bit hold_fetch = 1'b0;
  int cnt = 0;
  int fetch_cnt = 0;

  function automatic logic [7:0] memval(input logic [24:0] a);
    case (a)
      25'h0083E9: return ptr_lo;
      25'h0083EA: return ptr_hi;
      25'h008995: return 8'hAA;
      25'h008996: return 8'hBB;
      25'h008997: return 8'hCC;
      default:    return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    mem_ack = 1'b0;
    if (mem_rd && mem_addr >= 25'h008995) fetch_cnt++;
    if (mem_rd && !(hold_fetch && mem_addr >= 25'h008995)) begin
      cnt++;
      if (cnt >= lat) begin
        mem_ack  = 1'b1;
        mem_data = memval(mem_addr);
        cnt      = 0;
      end
    end else begin
      cnt = 0;
    end
  end

  function automatic bit cond(input int w);
    case (w)
      0: return ioctl_din_valid;
      1: return len_valid;
      2: return !uploading;
      3: return mem_rd && (mem_addr == 25'h008995);
      4: return mem_rd;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input int w, input string tag);
    int n = 0;
    @(negedge clk);
    while (!cond(w) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cond(w)) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic start_up();
    @(negedge clk);
    ioctl_upload = 1'b1;
  endtask

  task automatic stop_up(input string tag);
    @(negedge clk);
    ioctl_upload = 1'b0;
    wait_cond(2, tag);
    repeat (2) @(negedge clk);
  endtask

  task automatic rd_pulse();
    @(negedge clk);
    ioctl_rd = 1'b1;
    @(negedge clk);
    ioctl_rd = 1'b0;
  endtask

  int snap;

  initial begin
    // Reset with upload already high: must not start once released.
    repeat (2) @(negedge clk);
    chk("rst_uploading", uploading, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_din", ioctl_din, 0);
    chk("rst_flags", {ioctl_din_valid, ioctl_eof, len_valid, overrun}, 0);
    chk("rst_len", upload_len, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("high_out_of_reset", {uploading, mem_rd}, 0);
    ioctl_upload = 1'b0;
    repeat (2) @(negedge clk);

    // Pointer equal to base: empty program, no program fetch.
    ptr_lo = 8'h95; ptr_hi = 8'h89;
    snap = fetch_cnt;
    start_up();
    wait_cond(1, "t1_len");
    chk("t1_len", upload_len, 0);
    chk("t1_eof", ioctl_eof, 1);
    chk("t1_uploading", uploading, 1);
    repeat (3) @(negedge clk);
    chk("t1_no_fetch", fetch_cnt - snap, 0);
    stop_up("t1_stop");
    chk("t1_eof_clr", {ioctl_eof, len_valid}, 0);

    // Three-byte program.
    ptr_lo = 8'h98; ptr_hi = 8'h89;
    start_up();
    wait_cond(0, "t2_b0");
    chk("t2_len", upload_len, 3);
    chk("t2_b0", ioctl_din, 8'hAA);
    rd_pulse();
    wait_cond(0, "t2_b1");
    chk("t2_b1", ioctl_din, 8'hBB);
    rd_pulse();
    wait_cond(0, "t2_b2");
    chk("t2_b2", ioctl_din, 8'hCC);
    rd_pulse();
    chk("t2_eof", ioctl_eof, 1);
    chk("t2_din0", ioctl_din, 0);
    chk("t2_valid0", ioctl_din_valid, 0);
    rd_pulse();
    chk("t2_rd_after_eof", {ioctl_eof, ioctl_din}, 9'h100);
    chk("t2_overrun", overrun, 0);
    stop_up("t2_stop");

    // Pointer below base, then clamp.
    ptr_lo = 8'h00; ptr_hi = 8'h80;
    start_up();
    wait_cond(1, "t3a_len");
    chk("t3a_len", upload_len, 0);
    chk("t3a_eof", ioctl_eof, 1);
    stop_up("t3a_stop");
    ptr_lo = 8'hFF; ptr_hi = 8'hFF;
    start_up();
    wait_cond(1, "t3b_len");
    chk("t3b_len", upload_len, 25'h007000);
    chk("t3b_eof", ioctl_eof, 0);
    stop_up("t3b_stop");

    // Drop upload with a fetch outstanding.
    hold_fetch = 1'b1;
    ptr_lo = 8'h98; ptr_hi = 8'h89;
    start_up();
    wait_cond(3, "t4_fetch");
    @(negedge clk);
    ioctl_upload = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_rd_held", mem_rd, 1);
    chk("t4_still_up", uploading, 1);
    chk("t4_flags_clr", {ioctl_din_valid, ioctl_eof, len_valid}, 0);
    hold_fetch = 1'b0;
    @(negedge clk);
    chk("t4_ack", mem_ack, 1);
    @(negedge clk);
    chk("t4_rd_drop", mem_rd, 0);
    chk("t4_up_c1", uploading, 1);
    chk("t4_discard", ioctl_din_valid, 0);
    @(negedge clk);
    chk("t4_up_c2", uploading, 1);
    @(negedge clk);
    chk("t4_up_c3", uploading, 0);
    repeat (2) @(negedge clk);

    // Early ioctl_rd during a slow fetch.
    lat = 4;
    start_up();
    wait_cond(0, "t5_b0");
    chk("t5_b0", ioctl_din, 8'hAA);
    rd_pulse();
    rd_pulse();
    chk("t5_overrun", overrun, 1);
    chk("t5_addr", mem_addr, 25'h008996);
    wait_cond(0, "t5_b1");
    chk("t5_b1", ioctl_din, 8'hBB);
    chk("t5_sticky", overrun, 1);
    stop_up("t5_stop");
    lat = 1;
    start_up();
    wait_cond(1, "t5_restart");
    chk("t5_overrun_clr", overrun, 0);
    stop_up("t5_stop2");

    // Asynchronous reset mid-fetch.
    lat = 4;
    start_up();
    wait_cond(3, "t6_fetch");
    #2 reset_n = 1'b0;
    #1;
    chk("t6_mem_rd", mem_rd, 0);
    chk("t6_uploading", uploading, 0);
    chk("t6_flags", {ioctl_din_valid, ioctl_eof, len_valid, overrun}, 0);
    chk("t6_len", upload_len, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_autostart", uploading, 0);
    ioctl_upload = 1'b0;
    lat = 1;
    repeat (2) @(negedge clk);
    start_up();
    wait_cond(4, "t6_restart");
    chk("t6_ptr_lo_addr", mem_addr, 25'h0083E9);
    stop_up("t6_stop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
